uartprobe_axi_seq: RTL and testbench
====================================

Name: uartprobe_axi_seq

Overview:
Single-outstanding AXI4 master sequencer for the UART probe.
- Takes one byte-wide read or write command from the probe command decoder.
- Drives the AR/R or AW/W/B channels with correct valid/ready handshakes and a per-transaction timeout.
- Returns read data plus response code to the decoder, which forwards them over UART.
- Replaces the probe's ad-hoc go-flag registers as the owner of the m_axi_* bus.

Parameters:
AXI_ADDR_ON_RESET, 32'b0, value of m_axi_araddr/m_axi_awaddr out of reset.
TIMEOUT_CYCLES, 1024, cycles a transaction may wait in any bus state before abort; 0 disables the timeout; valid range 0..65535.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous reset, active-high.
cmd_valid  in  1  command offered.
cmd_ready  out  1  sequencer can accept a command.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  32  byte address.
cmd_wdata  in  8  write data.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed.
rsp_write  out  1  echoes cmd_write of the completed command.
rsp_rdata  out  8  read data; 0 for writes and timeouts.
rsp_resp  out  2  AXI RRESP/BRESP; 2'b10 on timeout.
rsp_timeout  out  1  transaction aborted by timeout.
m_axi_araddr, m_axi_arvalid, m_axi_arready, m_axi_arsize[2:0]  AR channel; arsize tied 3'b000.
m_axi_rdata[7:0], m_axi_rresp[1:0], m_axi_rvalid, m_axi_rready  R channel.
m_axi_awaddr, m_axi_awvalid, m_axi_awready, m_axi_awsize[2:0]  AW channel; awsize tied 3'b000.
m_axi_wdata[7:0], m_axi_wstrb[0:0], m_axi_wvalid, m_axi_wready  W channel; wstrb tied 1'b1.
m_axi_bresp[1:0], m_axi_bvalid, m_axi_bready  B channel.

Behaviour:
- Reset values:
  - state IDLE, cmd_ready=1.
  - All valids and readies low.
  - rsp_* outputs 0.
  - Address regs = AXI_ADDR_ON_RESET.
  - wdata = 0.
  - Timeout counter 0.
- Reset asserted mid-transaction: next cycle all m_axi valids/readies low, no response produced.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr/wdata/write.
    - Read goes to RD_A.
    - Write goes to WR_AW.
    - First valid rises the cycle after acceptance.
  - RD_A: arvalid=1, address stable. arready high → RD_R.
  - RD_R: rready=1. rvalid high → capture rdata/rresp → RESP.
  - WR_AW: awvalid and wvalid both asserted from the first cycle.
    - Each drops the cycle after its own ready is sampled high; done flags aw_done/w_done track this.
    - awready and wready in the same cycle → both done at once.
    - Both done → WR_B.
  - WR_B: bready=1. bvalid high → capture bresp → RESP. bready is 0 in all other states.
  - RESP: rsp_valid=1 with stable fields until rsp_ready is sampled high → IDLE. cmd_ready=0 throughout.
- Only one command is outstanding; cmd_ready is low in every non-IDLE state.
- Timeout:
  - 16-bit counter cleared on command acceptance, incremented each cycle in RD_A, RD_R, WR_AW, WR_B.
  - Count reaching TIMEOUT_CYCLES−1 without completion → drop all valids/readies, go to RESP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
  - Completion in the same cycle as expiry wins: normal response, timeout=0.
  - Deliberate protocol abort; documented for debug use only.
- rresp/bresp values are passed through unmodified; no retry.
- Minimum latencies, ready tied high: read = accept + 3 cycles to rsp_valid; write = accept + 3 cycles.

Optional Feature:
UARTPROBE_AXI_SEQ_STATS_EN.
- Defined: adds output ports stat_txn[15:0] and stat_err[7:0].
  - stat_txn increments per completed response handshake.
  - stat_err increments when that response has rsp_resp≠0 or rsp_timeout=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Read addr 0x0000_1234, slave arready after 2 cycles, rvalid with rdata 0xA5, rresp 0 → araddr 0x1234 held stable; rsp rdata=0xA5, resp=0, timeout=0, write=0.
- Write 0x5A to 0x8000_0000, awready and wready asserted same cycle, bresp 2'b00 → AW/W each one handshake; m_axi_wdata=0x5A; rsp write=1, resp=0.
- Write with wready 3 cycles before awready, bresp 2'b10 → wvalid drops after its handshake while awvalid stays high; single bready handshake; rsp resp=2'b10.
- TIMEOUT_CYCLES=16, read with arready never asserted → arvalid drops; rsp_valid rises 16 cycles after acceptance with timeout=1, resp=2'b10, rdata=0.
- rsp_ready held low 10 cycles, new cmd_valid offered meanwhile → cmd_ready stays 0; rsp fields stable; command accepted only after the RESP→IDLE handshake.
- Reset pulsed while in WR_B → next cycle all valids/readies 0, cmd_ready=1, no rsp_valid; with stats macro defined, stat_txn=0.

Source files
------------

// File: rtl/uartprobe_axi_seq.sv
// Single-outstanding AXI4 master sequencer: one byte read or write per command, with a per-transaction timeout.
// Optional macro UARTPROBE_AXI_SEQ_STATS_EN adds stat_txn/stat_err response counters.
module uartprobe_axi_seq #(
   parameter logic [31:0] AXI_ADDR_ON_RESET = 32'b0,
   parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_write,
   output logic [7:0]  rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        rsp_timeout,
   output logic [31:0] m_axi_araddr,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   output logic [2:0]  m_axi_arsize,
   input  logic [7:0]  m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   output logic [31:0] m_axi_awaddr,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [2:0]  m_axi_awsize,
   output logic [7:0]  m_axi_wdata,
   output logic [0:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
`ifdef UARTPROBE_AXI_SEQ_STATS_EN
   output logic        m_axi_bready,
   output logic [15:0] stat_txn,
   output logic [7:0]  stat_err
`else
   output logic        m_axi_bready
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_R, S_WR_AW, S_WR_B, S_RESP} state_t;

   localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

   state_t      r_state, w_state_next;
   logic [31:0] r_addr;
   logic [7:0]  r_wdata;
   logic        r_write;
   logic        r_aw_done, r_w_done;
   logic [15:0] r_cnt;
   logic        r_rsp_write, r_rsp_timeout;
   logic [7:0]  r_rsp_rdata;
   logic [1:0]  r_rsp_resp;
   logic        w_expired, w_abort, w_aw_fin, w_w_fin;

   // >= rather than == so a count that slips past the last value while progressing still expires
   assign w_expired = TO_EN && (r_cnt >= TO_LAST);
   assign w_aw_fin  = r_aw_done | m_axi_awready;
   assign w_w_fin   = r_w_done  | m_axi_wready;

   always_comb begin
      w_state_next  = r_state;
      w_abort       = 1'b0;
      cmd_ready     = 1'b0;
      rsp_valid     = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) w_state_next = cmd_write ? S_WR_AW : S_RD_A;
         end
         S_RD_A: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) w_state_next = S_RD_R;
            else if (w_expired) w_abort = 1'b1;
         end
         S_RD_R: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) w_state_next = S_RESP;
            else if (w_expired) w_abort = 1'b1;
         end
         S_WR_AW: begin
            m_axi_awvalid = !r_aw_done;
            m_axi_wvalid  = !r_w_done;
            if (w_aw_fin && w_w_fin) w_state_next = S_WR_B;
            else if (w_expired) w_abort = 1'b1;
         end
         S_WR_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) w_state_next = S_RESP;
            else if (w_expired) w_abort = 1'b1;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
      if (w_abort) w_state_next = S_RESP;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_addr        <= AXI_ADDR_ON_RESET;
         r_wdata       <= 8'd0;
         r_write       <= 1'b0;
         r_aw_done     <= 1'b0;
         r_w_done      <= 1'b0;
         r_cnt         <= 16'd0;
         r_rsp_write   <= 1'b0;
         r_rsp_rdata   <= 8'd0;
         r_rsp_resp    <= 2'b00;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: if (cmd_valid) begin
               r_addr    <= cmd_addr;
               r_wdata   <= cmd_wdata;
               r_write   <= cmd_write;
               r_aw_done <= 1'b0;
               r_w_done  <= 1'b0;
               r_cnt     <= 16'd0;
            end
            S_RD_A, S_RD_R, S_WR_B: r_cnt <= r_cnt + 16'd1;
            S_WR_AW: begin
               r_cnt <= r_cnt + 16'd1;
               if (m_axi_awready) r_aw_done <= 1'b1;
               if (m_axi_wready)  r_w_done  <= 1'b1;
            end
            default: ;
         endcase
         if (r_state == S_RD_R && m_axi_rvalid) begin
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= m_axi_rdata;
            r_rsp_resp    <= m_axi_rresp;
            r_rsp_timeout <= 1'b0;
         end else if (r_state == S_WR_B && m_axi_bvalid) begin
            r_rsp_write   <= 1'b1;
            r_rsp_rdata   <= 8'd0;
            r_rsp_resp    <= m_axi_bresp;
            r_rsp_timeout <= 1'b0;
         end else if (w_abort) begin
            r_rsp_write   <= r_write;
            r_rsp_rdata   <= 8'd0;
            r_rsp_resp    <= 2'b10;
            r_rsp_timeout <= 1'b1;
         end
      end
   end

   assign rsp_write    = r_rsp_write;
   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_resp     = r_rsp_resp;
   assign rsp_timeout  = r_rsp_timeout;
   assign m_axi_araddr = r_addr;
   assign m_axi_awaddr = r_addr;
   assign m_axi_wdata  = r_wdata;
   assign m_axi_arsize = 3'b000;
   assign m_axi_awsize = 3'b000;
   assign m_axi_wstrb  = 1'b1;

`ifdef UARTPROBE_AXI_SEQ_STATS_EN
   logic [15:0] r_stat_txn;
   logic [7:0]  r_stat_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_txn <= 16'd0;
         r_stat_err <= 8'd0;
      end else if (rsp_valid && rsp_ready) begin
         if (r_stat_txn != 16'hFFFF) r_stat_txn <= r_stat_txn + 16'd1;
         if ((r_rsp_resp != 2'b00 || r_rsp_timeout) && r_stat_err != 8'hFF)
            r_stat_err <= r_stat_err + 8'd1;
      end
   end

   assign stat_txn = r_stat_txn;
   assign stat_err = r_stat_err;
`endif

endmodule

// File: tb/tb_uartprobe_axi_seq.sv
// Directed bench for uartprobe_axi_seq (TIMEOUT_CYCLES=16); slave side driven by hand, expectations hand-computed.
module tb_uartprobe_axi_seq;
   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
   logic [7:0]  rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] araddr, awaddr;
   logic        arvalid, arready, rvalid, rready, awvalid, awready;
   logic        wvalid, wready, bvalid, bready;
   logic [2:0]  arsize, awsize;
   logic [7:0]  rdata, wdata;
   logic [1:0]  rresp, bresp;
   logic [0:0]  wstrb;
`ifdef UARTPROBE_AXI_SEQ_STATS_EN
   logic [15:0] stat_txn;
   logic [7:0]  stat_err;
`endif

   int errors = 0;
   int checks = 0;
   int n;

   always #5 clk = ~clk;

   uartprobe_axi_seq #(.AXI_ADDR_ON_RESET(32'h0), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_arsize(arsize),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
      .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_awsize(awsize),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
`ifdef UARTPROBE_AXI_SEQ_STATS_EN
      .m_axi_bready(bready), .stat_txn(stat_txn), .stat_err(stat_err)
`else
      .m_axi_bready(bready)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rsp_handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rsp_valid_cleared", rsp_valid, 1'b0);
      chk("cmd_ready_back", cmd_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
      repeat (3) tick();
      reset = 1'b0;

      // reset state
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
      chk("rst_readies", {rready, bready}, 2'b00);
      chk("rst_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, 13'd0);
      chk("rst_araddr", araddr, 32'h0);
      chk("rst_awaddr", awaddr, 32'h0);
      chk("rst_wdata", wdata, 8'h00);
      chk("tied_sizes_strb", {arsize, awsize, wstrb}, 7'b0000001);

      // read, arready after 2 cycles
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_1234;
      tick();
      cmd_valid = 1'b0; cmd_addr = 32'hDEAD_BEEF;
      chk("rd_arvalid", arvalid, 1'b1);
      chk("rd_cmd_ready_low", cmd_ready, 1'b0);
      chk("rd_araddr", araddr, 32'h0000_1234);
      tick();
      chk("rd_araddr_stable", araddr, 32'h0000_1234);
      chk("rd_arvalid_held", arvalid, 1'b1);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      chk("rd_arvalid_drop", arvalid, 1'b0);
      chk("rd_rready", rready, 1'b1);
      rvalid = 1'b1; rdata = 8'hA5; rresp = 2'b00;
      tick();
      rvalid = 1'b0; rdata = 8'h00;
      chk("rd_rready_drop", rready, 1'b0);
      chk("rd_rsp_valid", rsp_valid, 1'b1);
      chk("rd_rsp_fields", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, {1'b0, 1'b0, 2'b00, 8'hA5});
      rsp_handshake();

      // write, awready and wready together
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8000_0000; cmd_wdata = 8'h5A;
      tick();
      cmd_valid = 1'b0;
      chk("wr1_valids", {awvalid, wvalid}, 2'b11);
      chk("wr1_awaddr", awaddr, 32'h8000_0000);
      chk("wr1_wdata", wdata, 8'h5A);
      awready = 1'b1; wready = 1'b1;
      tick();
      awready = 1'b0; wready = 1'b0;
      chk("wr1_valids_drop", {awvalid, wvalid}, 2'b00);
      chk("wr1_bready", bready, 1'b1);
      bvalid = 1'b1; bresp = 2'b00;
      tick();
      bvalid = 1'b0;
      chk("wr1_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata},
          {1'b1, 1'b1, 1'b0, 2'b00, 8'h00});
      rsp_handshake();

      // write, wready 3 cycles ahead of awready, SLVERR
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0010; cmd_wdata = 8'hC3;
      tick();
      cmd_valid = 1'b0;
      wready = 1'b1;
      tick();
      wready = 1'b0;
      chk("wr2_wvalid_drop", wvalid, 1'b0);
      chk("wr2_awvalid_held", awvalid, 1'b1);
      tick();
      tick();
      chk("wr2_awvalid_still", {awvalid, wvalid, bready}, 3'b100);
      awready = 1'b1;
      tick();
      awready = 1'b0;
      chk("wr2_in_wr_b", {awvalid, wvalid, bready}, 3'b001);
      bvalid = 1'b1; bresp = 2'b10;
      tick();
      bvalid = 1'b0; bresp = 2'b00;
      chk("wr2_bready_drop", bready, 1'b0);
      chk("wr2_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp}, {1'b1, 1'b1, 1'b0, 2'b10});
      rsp_handshake();

      // read timeout, arready never asserted
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040;
      tick();
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         if (n == 15) chk("to_arvalid_last", arvalid, 1'b1);
         tick();
         n++;
      end
      chk("to_latency", n, 16);
      chk("to_arvalid_drop", arvalid, 1'b0);
      chk("to_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata},
          {1'b1, 1'b0, 1'b1, 2'b10, 8'h00});

      // response back-pressure while a new command is offered
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0099;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_cmd_ready", cmd_ready, 1'b0);
         chk("bp_rsp_stable", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b10, 8'h00});
      end
      chk("bp_no_arvalid", arvalid, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("bp_idle_ready", cmd_ready, 1'b1);
      chk("bp_rsp_cleared", rsp_valid, 1'b0);
      tick();
      cmd_valid = 1'b0;
      chk("bp_accept_arvalid", arvalid, 1'b1);
      chk("bp_accept_araddr", araddr, 32'h0000_0099);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 8'h3C; rresp = 2'b01;
      tick();
      rvalid = 1'b0;
      chk("bp_rd_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b01, 8'h3C});
      rsp_handshake();
`ifdef UARTPROBE_AXI_SEQ_STATS_EN
      chk("stat_txn_count", stat_txn, 16'd5);
      chk("stat_err_count", stat_err, 8'd3);
`endif

      // reset while in WR_B
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0020; cmd_wdata = 8'h11;
      tick();
      cmd_valid = 1'b0;
      awready = 1'b1; wready = 1'b1;
      tick();
      awready = 1'b0; wready = 1'b0;
      chk("rst2_in_wr_b", bready, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_all_low", {arvalid, rready, awvalid, wvalid, bready}, 5'b00000);
      chk("rst2_cmd_ready", cmd_ready, 1'b1);
      chk("rst2_no_rsp", rsp_valid, 1'b0);
`ifdef UARTPROBE_AXI_SEQ_STATS_EN
      chk("rst2_stat_txn", stat_txn, 16'd0);
`endif
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      chk("rst2_still_no_rsp", rsp_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
